// File: rtl/mem_ext_arb.sv
// mem_ext_arb: two-requester round-robin arbiter and zero-scrub initializer
// for a one-read-port / one-write-port byte-masked RAM. One read and one
// write may be granted per cycle; a same-address read/write pair defers the read.
module mem_ext_arb #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 64,
  parameter int INIT_ZERO = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                rq0_valid,
  output logic                rq0_ready,
  input  logic                rq0_write,
  input  logic [ADDR_W-1:0]   rq0_addr,
  input  logic [DATA_W-1:0]   rq0_wdata,
  input  logic [DATA_W/8-1:0] rq0_mask,
  input  logic                rq1_valid,
  output logic                rq1_ready,
  input  logic                rq1_write,
  input  logic [ADDR_W-1:0]   rq1_addr,
  input  logic [DATA_W-1:0]   rq1_wdata,
  input  logic [DATA_W/8-1:0] rq1_mask,
  output logic                rs0_valid,
  output logic [DATA_W-1:0]   rs0_data,
  output logic                rs1_valid,
  output logic [DATA_W-1:0]   rs1_data,
  output logic [ADDR_W-1:0]   R0_addr,
  output logic                R0_en,
  input  logic [DATA_W-1:0]   R0_data,
  output logic [ADDR_W-1:0]   W0_addr,
  output logic                W0_en,
  output logic [DATA_W-1:0]   W0_data,
  output logic [DATA_W/8-1:0] W0_mask,
  output logic                init_done
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        rs_vld_q, rs_vld_d;

  logic [1:0]             req_valid, req_write, rd_req, wr_req;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0][MASK_W-1:0] req_mask;
  logic                   rd_any, wr_any, rd_win, wr_win;
  logic                   collide, rd_gnt, wr_gnt;

  assign req_valid = {rq1_valid, rq0_valid};
  assign req_write = {rq1_write, rq0_write};
  assign req_addr  = {rq1_addr, rq0_addr};
  assign req_wdata = {rq1_wdata, rq0_wdata};
  assign req_mask  = {rq1_mask, rq0_mask};
  assign rd_req    = req_valid & ~req_write;
  assign wr_req    = req_valid & req_write;

  // Per-channel round-robin winner; the pointer only matters when both compete.
  // A read hitting the address being written this cycle loses to the write.
  always_comb begin
    rd_any  = |rd_req;
    wr_any  = |wr_req;
    rd_win  = rd_req[1] & (~rd_req[0] | rd_ptr_q);
    wr_win  = wr_req[1] & (~wr_req[0] | wr_ptr_q);
    collide = rd_any & wr_any & (req_addr[rd_win] == req_addr[wr_win]);
    rd_gnt  = rd_any & ~collide;
    wr_gnt  = wr_any;
  end

  // Next state and RAM/handshake drive; all outputs are held low while in reset.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    rs_vld_d  = '0;
    rq0_ready = 1'b0;
    rq1_ready = 1'b0;
    R0_en     = 1'b0;
    R0_addr   = '0;
    W0_en     = 1'b0;
    W0_addr   = '0;
    W0_data   = '0;
    W0_mask   = '0;
    init_done = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_INIT: begin
          W0_en   = 1'b1;
          W0_addr = cnt_q;
          W0_mask = '1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = ST_RUN;
        end
        ST_RUN: begin
          init_done = 1'b1;
          if (rd_gnt) begin
            R0_en            = 1'b1;
            R0_addr          = req_addr[rd_win];
            rd_ptr_d         = ~rd_win;
            rs_vld_d[rd_win] = 1'b1;
          end
          if (wr_gnt) begin
            W0_en    = 1'b1;
            W0_addr  = req_addr[wr_win];
            W0_data  = req_wdata[wr_win];
            W0_mask  = req_mask[wr_win];
            wr_ptr_d = ~wr_win;
          end
          rq0_ready = (rd_gnt & ~rd_win) | (wr_gnt & ~wr_win);
          rq1_ready = (rd_gnt & rd_win) | (wr_gnt & wr_win);
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // State, scrub counter, arbitration pointers and one-cycle response tag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      cnt_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      rs_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rs_vld_q <= rs_vld_d;
    end
  end

  // RAM read data is returned to whichever requester owns the response.
  assign rs0_valid = reset_n & rs_vld_q[0];
  assign rs1_valid = reset_n & rs_vld_q[1];
  assign rs0_data  = R0_data;
  assign rs1_data  = R0_data;

endmodule
